// File: rtl/psum_accum_if.sv
// Bus bundle for psum_accum: product stream in, compressed nonzero stream out.
interface psum_accum_if #(
  parameter int DATA_W = 32
) ();
  logic              valid_in;
  logic [DATA_W-1:0] indata;
  logic [31:0]       indataPosition;
  logic [4:0]        inmap_in;
  logic              rdy;
  logic [5:0]        datasize;
  logic              layer_done_in;
  logic              next_stage_rdy;
  logic              valid_out;
  logic [DATA_W-1:0] nz;
  logic [31:0]       nzposition;
  logic              layer_done_out;

  modport slave (
    input  valid_in, indata, indataPosition, inmap_in, datasize,
           layer_done_in, next_stage_rdy,
    output rdy, valid_out, nz, nzposition, layer_done_out
  );

  modport master (
    output valid_in, indata, indataPosition, inmap_in, datasize,
           layer_done_in, next_stage_rdy,
    input  rdy, valid_out, nz, nzposition, layer_done_out
  );
endinterface

// File: rtl/psum_accum.sv
// Scatter-accumulate of conv products into a partial-sum buffer, drained as a
// nonzero (value, position) stream on every map change and at layer end.
module psum_accum #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic         clk,
  input  logic         reset,
  psum_accum_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, DONE} state_t;

  state_t            r_state, w_state_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_ram_q;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [4:0]        r_cur_map;
  logic              r_dirty;
  logic              r_s1_vld;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_fwd;
  logic [DATA_W-1:0] r_fwd_val;
  logic [12:0]       r_scan;
  logic [12:0]       r_n;
  logic              r_dv;
  logic [ADDR_W-1:0] r_dq_addr;
  logic              r_valid_out;
  logic [DATA_W-1:0] r_nz;
  logic [31:0]       r_nzpos;

  logic [ADDR_W-1:0] w_in_addr;
  logic              w_map_chg, w_rdy, w_acc;
  logic [DATA_W-1:0] w_s1_rd, w_s1_sum;
  logic              w_adv, w_scan_left, w_issue, w_load, w_drain_end, w_re;
  logic [11:0]       w_n_new;
  logic              w_we;
  logic [ADDR_W-1:0] w_wa, w_ra;
  logic [DATA_W-1:0] w_wd;
  logic              w_unused_pos;

  assign w_in_addr    = bus.indataPosition[ADDR_W-1:0];
  assign w_unused_pos = ^bus.indataPosition[31:ADDR_W];
  assign w_map_chg    = bus.valid_in & r_dirty & (bus.inmap_in != r_cur_map);
  assign w_rdy        = (r_state == ACCUM) & ~w_map_chg & ~bus.layer_done_in;
  assign w_acc        = bus.valid_in & w_rdy;
  // S1 operand: bypass RAM when the previous product hit the same address
  assign w_s1_rd      = r_fwd ? r_fwd_val : r_ram_q;
  assign w_s1_sum     = w_s1_rd + r_s1_data;
  // drain pipeline advances unless the output word is blocked downstream
  assign w_adv        = ~(r_valid_out & ~bus.next_stage_rdy);
  assign w_scan_left  = (r_scan != r_n);
  assign w_issue      = (r_state == DRAIN) & w_adv & w_scan_left;
  assign w_load       = (r_state == DRAIN) & w_adv & r_dv & (r_ram_q != '0);
  assign w_drain_end  = (r_state == DRAIN) & w_adv & ~w_scan_left & ~r_dv;
  assign w_n_new      = 12'(bus.datasize) * 12'(bus.datasize);
  assign w_re         = w_acc | w_issue;
  assign w_ra         = (r_state == DRAIN) ? ADDR_W'(r_scan) : w_in_addr;

  assign bus.rdy            = w_rdy;
  assign bus.valid_out      = r_valid_out;
  assign bus.nz             = r_nz;
  assign bus.nzposition     = r_nzpos;
  assign bus.layer_done_out = (r_state == DONE);

  // next-state: drain waits for the in-flight S1 write before scanning
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR: if (&r_clr_addr) w_state_next = ACCUM;
      ACCUM: begin
        if (bus.layer_done_in & ~r_dirty)
          w_state_next = DONE;
        else if ((w_map_chg | bus.layer_done_in) & ~r_s1_vld)
          w_state_next = DRAIN;
      end
      DRAIN: if (w_drain_end) w_state_next = bus.layer_done_in ? DONE : ACCUM;
      DONE:  w_state_next = DONE;
      default: w_state_next = CLEAR;
    endcase
  end

  // single write port shared by clear sweep, drain clear and S1 accumulate
  always_comb begin
    w_we = 1'b0;
    w_wa = r_clr_addr;
    w_wd = '0;
    if (r_state == CLEAR) begin
      w_we = 1'b1;
    end else if (w_issue) begin
      w_we = 1'b1;
      w_wa = ADDR_W'(r_scan);
    end else if (r_s1_vld) begin
      w_we = 1'b1;
      w_wa = r_s1_addr;
      w_wd = w_s1_sum;
    end
  end

  // partial-sum buffer: read-first so drain sees data before its clear
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wa] <= w_wd;
    if (w_re) r_ram_q <= r_mem[w_ra];
  end

  // control, RMW pipeline, drain scan and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= CLEAR;
      r_clr_addr  <= '0;
      r_cur_map   <= '0;
      r_dirty     <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_data   <= '0;
      r_fwd       <= 1'b0;
      r_fwd_val   <= '0;
      r_scan      <= '0;
      r_n         <= '0;
      r_dv        <= 1'b0;
      r_dq_addr   <= '0;
      r_valid_out <= 1'b0;
      r_nz        <= '0;
      r_nzpos     <= '0;
    end else begin
      r_state  <= w_state_next;
      r_s1_vld <= w_acc;
      if (r_state == CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
      if (w_acc) begin
        r_s1_addr <= w_in_addr;
        r_s1_data <= bus.indata;
        r_fwd     <= r_s1_vld & (r_s1_addr == w_in_addr);
        r_fwd_val <= w_s1_sum;
        r_dirty   <= 1'b1;
        r_cur_map <= bus.inmap_in;
      end
      if ((r_state == ACCUM) && (w_state_next == DRAIN)) begin
        r_n    <= {1'b0, w_n_new};
        r_scan <= '0;
      end
      if (w_issue) r_scan <= r_scan + 13'd1;
      if (w_adv) begin
        r_dv      <= w_issue;
        r_dq_addr <= ADDR_W'(r_scan);
      end
      if (w_load) begin
        r_valid_out <= 1'b1;
        r_nz        <= r_ram_q;
        r_nzpos     <= {r_cur_map, 15'b0, 12'(r_dq_addr)};
      end else if (r_valid_out & bus.next_stage_rdy) begin
        r_valid_out <= 1'b0;
      end
      if (w_drain_end) r_dirty <= 1'b0;
    end
  end
endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum with an output scoreboard.
`timescale 1ns/1ps
module tb_psum_accum;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  psum_accum_if #(.DATA_W(DATA_W)) bus ();

  psum_accum #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] v;
    logic [31:0] p;
  } word_t;

  word_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    last_acc;
  bit    prev_hold;
  word_t prev_word;

  function automatic logic [31:0] pos(input int m, input int a);
    return {5'(m), 15'b0, 12'(a)};
  endfunction

  function automatic word_t mkw(input logic [31:0] v, input logic [31:0] p);
    word_t w;
    w.v = v;
    w.p = p;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // output scoreboard and hold-stability check, sampled at the falling edge
  task automatic monitor();
    word_t cur;
    word_t e;
    cur = mkw(bus.nz, bus.nzposition);
    if (prev_hold) begin
      chk("hold_valid", 64'(bus.valid_out), 64'd1);
      chk("hold_word", cur, prev_word);
    end
    if (bus.valid_out && bus.next_stage_rdy) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_out observed=%h expected=none", cur);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_word", cur, e);
      end
    end
    prev_hold = bus.valid_out && !bus.next_stage_rdy;
    prev_word = cur;
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    last_acc = bus.valid_in & bus.rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int n;
    bus.valid_in       = 1'b0;
    bus.indata         = '0;
    bus.indataPosition = '0;
    bus.inmap_in       = '0;
    bus.layer_done_in  = 1'b0;
    bus.next_stage_rdy = 1'b1;
    bus.datasize       = 6'd4;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
    chk("rst_rdy", 64'(bus.rdy), 64'd0);
    chk("rst_layer_done_out", 64'(bus.layer_done_out), 64'd0);
    chk("rst_nz", 64'(bus.nz), 64'd0);
    chk("rst_nzposition", 64'(bus.nzposition), 64'd0);
    exp_q.delete();
    prev_hold = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (!bus.rdy && n < 5000) begin
      cyc();
      n++;
    end
    chk("clear_cycles", 64'(n), 64'd4096);
    chk("rdy_after_clear", 64'(bus.rdy), 64'd1);
  endtask

  task automatic send(input logic [31:0] v, input int a, input int m);
    int n;
    n = 0;
    bus.valid_in       = 1'b1;
    bus.indata         = v;
    bus.indataPosition = 32'(a);
    bus.inmap_in       = 5'(m);
    do begin
      cyc();
      n++;
    end while (!last_acc && n < 3000);
    chk("send_accept", 64'(last_acc), 64'd1);
    bus.valid_in = 1'b0;
  endtask

  task automatic finish_layer(input bit rand_bp);
    int n;
    n = 0;
    bus.layer_done_in = 1'b1;
    while (!bus.layer_done_out && n < 3000) begin
      if (rand_bp) bus.next_stage_rdy = 1'($urandom_range(0, 1));
      cyc();
      n++;
    end
    bus.next_stage_rdy = 1'b1;
    chk("layer_done_out", 64'(bus.layer_done_out), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("done_rdy", 64'(bus.rdy), 64'd0);
    chk("done_valid_out", 64'(bus.valid_out), 64'd0);
    cyc();
    chk("done_sticky", 64'(bus.layer_done_out), 64'd1);
  endtask

  initial begin
    int n;

    // forwarding on back-to-back same-address products
    do_reset();
    send(32'd5, 0, 0);
    send(32'd7, 0, 0);
    send(32'd3, 5, 0);
    exp_q.push_back(mkw(32'd12, pos(0, 0)));
    exp_q.push_back(mkw(32'd3, pos(0, 5)));
    finish_layer(1'b0);

    // map switch drains map0 before accepting map1
    do_reset();
    repeat (4) send(32'd2, 1, 0);
    exp_q.push_back(mkw(32'd8, pos(0, 1)));
    exp_q.push_back(mkw(32'd9, pos(1, 2)));
    bus.valid_in       = 1'b1;
    bus.indata         = 32'd9;
    bus.indataPosition = 32'd2;
    bus.inmap_in       = 5'd1;
    cyc();
    chk("rdy_drop_map_change", 64'(last_acc), 64'd0);
    send(32'd9, 2, 1);
    finish_layer(1'b0);

    // backpressure: words must hold stable while next_stage_rdy is low
    do_reset();
    send(32'd11, 2, 2);
    send(32'd22, 6, 2);
    send(32'd33, 15, 2);
    exp_q.push_back(mkw(32'd11, pos(2, 2)));
    exp_q.push_back(mkw(32'd22, pos(2, 6)));
    exp_q.push_back(mkw(32'd33, pos(2, 15)));
    bus.next_stage_rdy = 1'b0;
    bus.layer_done_in  = 1'b1;
    n = 0;
    while (!bus.valid_out && n < 100) begin
      cyc();
      n++;
    end
    chk("bp_valid_seen", 64'(bus.valid_out), 64'd1);
    repeat (5) cyc();
    chk("bp_nothing_consumed", 64'(exp_q.size()), 64'd3);
    finish_layer(1'b1);

    // wrap to zero is skipped; next map sees no residue
    do_reset();
    send(32'hFFFF_FFFF, 3, 0);
    send(32'd1, 3, 0);
    send(32'd4, 7, 0);
    send(32'd10, 4, 0);
    send(32'd20, 9, 0);
    exp_q.push_back(mkw(32'd10, pos(0, 4)));
    exp_q.push_back(mkw(32'd4, pos(0, 7)));
    exp_q.push_back(mkw(32'd20, pos(0, 9)));
    exp_q.push_back(mkw(32'd1, pos(1, 4)));
    exp_q.push_back(mkw(32'd2, pos(1, 9)));
    send(32'd1, 4, 1);
    send(32'd2, 9, 1);
    finish_layer(1'b0);

    // reset in the middle of a drain
    do_reset();
    send(32'd5, 1, 3);
    send(32'd6, 2, 3);
    bus.next_stage_rdy = 1'b0;
    bus.layer_done_in  = 1'b1;
    n = 0;
    while (!bus.valid_out && n < 100) begin
      cyc();
      n++;
    end
    chk("pre_reset_valid_out", 64'(bus.valid_out), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_drain_rst_valid_out", 64'(bus.valid_out), 64'd0);
    chk("mid_drain_rst_nz", 64'(bus.nz), 64'd0);
    chk("mid_drain_rst_rdy", 64'(bus.rdy), 64'd0);
    do_reset();

    // empty layer goes straight to done
    bus.layer_done_in = 1'b1;
    cyc();
    chk("empty_layer_done", 64'(bus.layer_done_out), 64'd1);
    chk("empty_layer_no_out", 64'(bus.valid_out), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
